// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared definitions for the keypad entry controller: key code constants,
//   the entry FSM state type and a small digit classification helper.
package keypad_pkg;

    localparam logic [3:0] K_START   = 4'hA;
    localparam logic [3:0] K_CLEAR   = 4'hB;
    localparam logic [3:0] K_CONFIRM = 4'hC;
    localparam logic [3:0] K_NONE    = 4'hF;

    typedef enum logic [1:0] {IDLE, ENTRY, OFFER, LOCKED} state_t;

    function automatic logic is_digit(input logic [3:0] c);
        return c <= 4'd9;
    endfunction

endpackage

// File: rtl/key_event_filter.sv
// key_event_filter
//   Resynchronises the scanner's key code, waits for it to settle and emits a
//   one-cycle press event when the settled code leaves "none".
//   Ports:
//     clk, reset  system clock, asynchronous active-low reset
//     key_code    raw scanner code (asynchronous to clk)
//     code        settled (filtered) key code, K_NONE after reset
//     press       one-cycle pulse: settled code went K_NONE -> other
module key_event_filter
    import keypad_pkg::*;
#(
    parameter int STABLE = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    output logic [3:0] code,
    output logic       press
);

    localparam int CW = $clog2(STABLE + 1);

    logic [3:0]    sync1, sync2;
    logic [CW-1:0] cnt;
    logic          settled;

    // cnt counts cycles sync2 has held its value; it is cleared on the edge
    // where sync2 takes a new value (sync1 differs from it). The code is
    // accepted on the edge that completes STABLE identical cycles.
    assign settled = (sync1 == sync2) && (cnt >= CW'(STABLE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= K_NONE;
            sync2 <= K_NONE;
            cnt   <= '0;
            code  <= K_NONE;
            press <= 1'b0;
        end else begin
            sync1 <= key_code;
            sync2 <= sync1;
            if (sync1 != sync2)
                cnt <= '0;
            else if (cnt != CW'(STABLE))
                cnt <= cnt + CW'(1);
            press <= 1'b0;
            if (settled) begin
                code  <= sync2;
                // only a release-then-press counts; code-to-code moves do not
                press <= (code == K_NONE) && (sync2 != K_NONE);
            end
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
//   Turns filtered keypad presses into a BCD set-point, offers it downstream
//   over valid/ready and then issues start/stop pulses.
//   Ports:
//     clk, reset  system clock, asynchronous active-low reset
//     key_code    raw scanner code
//     bcd         set-point, digit 0 in [3:0]
//     ndigits     digits entered so far
//     cfg_valid   set-point offered; cfg_ready accepts it
//     locked      set-point accepted, start/stop enabled
//     start/stop/overflow  one-cycle pulses
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int STABLE = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    key_code,
    output logic [4*DIGITS-1:0]           bcd,
    output logic [$clog2(DIGITS+1)-1:0]   ndigits,
    output logic                          cfg_valid,
    input  logic                          cfg_ready,
    output logic                          locked,
    output logic                          start,
    output logic                          stop,
    output logic                          overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int NW = $clog2(DIGITS + 1);

    logic [3:0]    code;
    logic          press;
    state_t        state, state_n;
    logic [BW-1:0] bcd_n;
    logic [NW-1:0] nd_n;
    logic          start_n, stop_n, ovf_n;

    key_event_filter #(.STABLE(STABLE)) u_filter (
        .clk      (clk),
        .reset    (reset),
        .key_code (key_code),
        .code     (code),
        .press    (press)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bcd       <= '0;
            ndigits   <= '0;
            cfg_valid <= 1'b0;
            locked    <= 1'b0;
            start     <= 1'b0;
            stop      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            bcd       <= bcd_n;
            ndigits   <= nd_n;
            cfg_valid <= (state_n == OFFER);
            locked    <= (state_n == LOCKED);
            start     <= start_n;
            stop      <= stop_n;
            overflow  <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        bcd_n   = bcd;
        nd_n    = ndigits;
        start_n = 1'b0;
        stop_n  = 1'b0;
        ovf_n   = 1'b0;
        case (state)
            IDLE: begin
                if (press && is_digit(code)) begin
                    bcd_n   = BW'(code);
                    nd_n    = NW'(1);
                    state_n = ENTRY;
                end
            end
            ENTRY: begin
                if (press) begin
                    if (is_digit(code)) begin
                        if (ndigits < NW'(DIGITS)) begin
                            bcd_n = (bcd << 4) | BW'(code);
                            nd_n  = ndigits + NW'(1);
                        end else begin
                            ovf_n = 1'b1;
                        end
                    end else if (code == K_CLEAR) begin
                        bcd_n   = '0;
                        nd_n    = '0;
                        state_n = IDLE;
                    end else if (code == K_CONFIRM) begin
                        state_n = OFFER;
                    end
                end
            end
            OFFER: begin
                // cfg_valid is high throughout OFFER, so ready alone means a
                // transfer; it wins over a simultaneous clear.
                if (cfg_ready) begin
                    state_n = LOCKED;
                end else if (press && code == K_CLEAR) begin
                    bcd_n   = '0;
                    nd_n    = '0;
                    state_n = IDLE;
                end
            end
            LOCKED: begin
                if (press && code == K_START) begin
                    start_n = 1'b1;
                end else if (press && code == K_CLEAR) begin
                    stop_n  = 1'b1;
                    bcd_n   = '0;
                    nd_n    = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequencing controller that sits behind the 4x4 matrix-keypad scanner and turns its held key codes into an operator command stream. It resynchronises and filters the scanner's 4-bit code, detects one event per physical press, assembles a multi-digit BCD set-point, offers it to the motion controller over a valid/ready handshake, and then issues start/stop pulses. It owns the entry/confirm/start policy so that the downstream datapath only ever sees complete, confirmed values.

## Interface
- DIGITS, 3, maximum number of BCD digits in a set-point (1..8)
- STABLE, 1024, clk cycles the synchronised code must stay constant before it is accepted (≥1)
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low
- key_code  in  4  scanner output; 0–9 digits, 0xA start, 0xB clear, 0xC confirm, 0xF none; 0xD/0xE unused; asynchronous to clk
- bcd  out  4*DIGITS  set-point, digit 0 (least significant) in [3:0]
- ndigits  out  $clog2(DIGITS+1)  digits entered so far
- cfg_valid  out  1  set-point offered to downstream
- cfg_ready  in  1  downstream accepts set-point when high with cfg_valid
- locked  out  1  set-point accepted, start/stop enabled
- start  out  1  one-cycle pulse
- stop  out  1  one-cycle pulse
- overflow  out  1  one-cycle pulse, digit rejected because buffer full

## Operation
- Filter: key_code → 2-flop synchroniser → stability counter; filtered code takes the synchronised value after STABLE consecutive identical cycles. Event = filtered code changes from 0xF to a non-0xF value. A change directly between two non-0xF codes is not an event; release (0xF) is required between presses.
- The FSM acts on the event cycle only; codes 0xD/0xE produce no action.
- IDLE (ndigits=0, bcd=0): digit → bcd=digit, ndigits=1, ENTRY. clear/confirm/start ignored.
- ENTRY: digit with ndigits<DIGITS → bcd shifted left one digit, new digit into digit 0, ndigits+1. Digit with ndigits=DIGITS → no change, overflow pulse. clear → bcd=0, ndigits=0, IDLE. confirm → OFFER. start ignored.
- OFFER: cfg_valid=1, bcd/ndigits frozen. cfg_ready=1 → LOCKED next cycle. clear event with cfg_ready=0 → IDLE, bcd=0, ndigits=0, cfg_valid drops. Clear in the same cycle as cfg_ready: the transfer completes, the FSM enters LOCKED, and the clear is discarded. Digits/confirm/start ignored.
- LOCKED: locked=1, bcd held. start → start pulse, stay LOCKED. clear → stop pulse, bcd=0, ndigits=0, IDLE. Digits/confirm ignored.
- Reset mid-operation: every state, counter and output returns to its reset value immediately; no stop pulse is generated.

## Timing
- Reset values: bcd=0, ndigits=0, cfg_valid=0, locked=0, start=0, stop=0, overflow=0, filtered code=0xF, FSM=IDLE.
- Event latency: the event is asserted 2+STABLE clk cycles after a key_code change that is held stable. The FSM output updates one cycle later.
- All outputs are registered; start/stop/overflow are high exactly one cycle per event.
- cfg_valid rises the cycle after the confirm event and stays high until the cycle after the handshake or an abort. locked rises in the same cycle cfg_valid falls on handshake.
- Stability counter: saturating, width $clog2(STABLE+1); it restarts on any change of the synchronised value.

## Structure
- Shared package keypad_pkg: key code constants K_START=4'hA, K_CLEAR=4'hB, K_CONFIRM=4'hC, K_NONE=4'hF; FSM state enum {IDLE, ENTRY, OFFER, LOCKED}.
- Sub-module key_event_filter: synchroniser, stability counter, filtered code and press-event output (parameter STABLE). The top level holds the FSM, digit shift register and handshake.

## Test plan
- Bench with STABLE=4, DIGITS=3. Press 1,2,3 (each released) then confirm → bcd=12'h123, ndigits=3, cfg_valid=1. Then cfg_ready=1 → locked=1 next cycle.
- Glitch: key_code=5 for 3 cycles then 0xF → no event, bcd=0, ndigits=0.
- Overflow: enter 4,5,6,7 → bcd=12'h456, one overflow pulse on the 7.
- In LOCKED: press start → one start pulse. Press clear → one stop pulse, bcd=0, IDLE. Start in IDLE → no pulse.
- OFFER with cfg_ready=0, press clear → cfg_valid drops, IDLE. Repeat the scenario with clear event and cfg_ready in the same cycle → LOCKED, no abort.
- Assert reset while in OFFER → all outputs 0 asynchronously. Code 5→3 without release → no event.
